iq_symbol_demod: RTL

Coherent I/Q symbol demodulator: the receive-side counterpart of the I/Q carrier modulator. It multiplies each 16-bit received mixer sample by the local I and Q carrier samples (8-bit LO). It integrates the products over one symbol period (integrate-and-dump) and slices each integral into the same 2-bit per-channel symbol code the transmit-side symbol generator produces. It sits after the mixer output and before any bit-level checking logic.

---
 rtl/iq_symbol_demod_if.sv | 22 ++
 rtl/iq_symbol_demod.sv | 109 ++++++++++
 2 files changed

// File: rtl/iq_symbol_demod_if.sv
// Sample/LO stream into the I/Q symbol demodulator and the recovered symbol
// stream out of it. The master drives samples; the slave is the demodulator.
interface iq_symbol_demod_if;
    logic [15:0] rx_in;
    logic        rx_valid;
    logic [7:0]  lo_i;
    logic [7:0]  lo_q;
    logic        sym_start;
    logic [1:0]  i_sym;
    logic [1:0]  q_sym;
    logic        sym_valid;

    modport master (
        output rx_in, rx_valid, lo_i, lo_q, sym_start,
        input  i_sym, q_sym, sym_valid
    );

    modport slave (
        input  rx_in, rx_valid, lo_i, lo_q, sym_start,
        output i_sym, q_sym, sym_valid
    );
endinterface

// File: rtl/iq_symbol_demod.sv
// Coherent I/Q integrate-and-dump demodulator: mix each sample with the LO,
// integrate over SPS accepted samples and slice each integral to +1/-1/erasure.
module iq_symbol_demod #(
    parameter int SPS    = 16,
    parameter int THRESH = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    iq_symbol_demod_if.slave  bus
);
    localparam int CNT_W = $clog2(SPS);
    localparam int ACC_W = 24 + CNT_W;
    localparam logic signed [ACC_W:0] THR = (ACC_W+1)'(THRESH);

    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         idx;
    logic                     idx_first;
    logic                     idx_last;

    logic signed [23:0]       rx_ext;
    logic signed [23:0]       lo_i_ext;
    logic signed [23:0]       lo_q_ext;

    logic signed [23:0]       p_i;
    logic signed [23:0]       p_q;
    logic                     pv;
    logic                     first_r;
    logic                     last_r;

    logic signed [ACC_W-1:0]  acc_i;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum_i;
    logic signed [ACC_W-1:0]  sum_q;

    logic [1:0]               i_sym;
    logic [1:0]               q_sym;
    logic                     sym_valid;

    // sym_start re-anchors the current sample as index 0 of a fresh symbol.
    assign idx       = bus.sym_start ? '0 : cnt;
    assign idx_first = (idx == '0);
    assign idx_last  = (idx == CNT_W'(SPS - 1));

    assign rx_ext   = 24'($signed(bus.rx_in));
    assign lo_i_ext = 24'($signed(bus.lo_i));
    assign lo_q_ext = 24'($signed(bus.lo_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            p_i     <= '0;
            p_q     <= '0;
            pv      <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            pv <= bus.rx_valid;
            if (bus.rx_valid) begin
                p_i     <= rx_ext * lo_i_ext;
                p_q     <= rx_ext * lo_q_ext;
                first_r <= idx_first;
                last_r  <= idx_last;
                cnt     <= idx_last ? '0 : idx + 1'b1;
            end
        end
    end

    // A first sample restarts the sum, dropping any partial symbol left behind by a resync.
    assign sum_i = first_r ? ACC_W'(p_i) : acc_i + ACC_W'(p_i);
    assign sum_q = first_r ? ACC_W'(p_q) : acc_q + ACC_W'(p_q);

    function automatic logic [1:0] slice(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W:0] se;
        logic [1:0]            code;
        se = (ACC_W+1)'(s);
        if (se > THR)
            code = 2'b01;
        else if (se < -THR)
            code = 2'b11;
        else
            code = 2'b00;
        return code;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i     <= '0;
            acc_q     <= '0;
            i_sym     <= 2'b00;
            q_sym     <= 2'b00;
            sym_valid <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            if (pv) begin
                acc_i <= last_r ? '0 : sum_i;
                acc_q <= last_r ? '0 : sum_q;
                if (last_r) begin
                    i_sym     <= slice(sum_i);
                    q_sym     <= slice(sum_q);
                    sym_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.i_sym     = i_sym;
    assign bus.q_sym     = q_sym;
    assign bus.sym_valid = sym_valid;
endmodule
